xosera_bus_responder: RTL
=========================

// Module: xosera_bus_responder
// PURPOSE
//  Target side of the 8-bit host register bus (CS/RD_NWR/BYTESEL/REG_NUM/DATA).
//  Synchronises the asynchronous host strobe to clk. Assembles high/low byte
//  writes into 16-bit register writes. Serves byte reads from a 16-bit
//  register read port. Sits between the top-level bus pins and the register
//  core, which sees only single-cycle word strobes.
// PARAMETERS
//  SYNC_STAGES   2   flip-flops in the bus_cs_n_i synchroniser (min 2)
// PORTS
//  clk            in   1   pixel clock; the only clock
//  reset_i        in   1   synchronous, active-high reset
//  bus_cs_n_i     in   1   host chip select, active low, asynchronous
//  bus_rd_nwr_i   in   1   1 = read, 0 = write; stable while CS low
//  bus_bytesel_i  in   1   0 = high byte, 1 = low byte
//  bus_reg_num_i  in   4   register number
//  bus_data_i     in   8   host write byte
//  bus_data_o     out  8   host read byte
//  reg_wr_o       out  1   one-cycle 16-bit register write strobe
//  reg_rd_o       out  1   one-cycle read-complete strobe (for auto-increment)
//  reg_num_o      out  4   register number for the current strobe / read mux
//  reg_wdata_o    out  16  assembled write word, valid with reg_wr_o
//  reg_rdata_i    in   16  register core read data for reg_num_o (comb. mux)
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; hi_byte = 8'h00; rd_word = 16'h0000;
//    synchroniser flops preset to 1 (CS deasserted).
//  - cs_sync = bus_cs_n_i after SYNC_STAGES flops.
//  - FSM: IDLE -> STROBE when cs_sync == 0. STROBE -> WAIT_REL unconditionally
//    (exactly one cycle). WAIT_REL -> IDLE when cs_sync == 1.
//    One CS assertion produces exactly one STROBE cycle, however long CS is held.
//  - On the IDLE->STROBE transition, latch rd_nwr, bytesel, reg_num and data.
//    The host keeps these stable for the whole CS-low interval.
//  - Write, high byte: hi_byte <= data. No strobe.
//  - Write, low byte: in STROBE, reg_wr_o = 1 and reg_wdata_o = {hi_byte, data}.
//    hi_byte is retained, so a low-only write reuses the last high byte.
//  - Read: reg_rd_o = 1 in STROBE only for a low-byte read.
//    bus_data_o = bytesel ? rd_word[7:0] : rd_word[15:8].
//  - reg_num_o = bus_reg_num_i registered every cycle while in IDLE; held
//    otherwise.
//  - Latency: CS fall -> STROBE is SYNC_STAGES+1 clocks (3 at default).
//    The host samples read data no earlier than SYNC_STAGES+2 clocks after CS
//    falls.
//  - Reset asserted mid-cycle: return to IDLE, no strobe. If CS is still low
//    when reset releases, cs_sync == 0 starts a fresh access (one STROBE).
//  - A CS glitch shorter than one clock is either filtered or produces a full
//    single access; it never produces more than one strobe.
// CONFIGURATION
//  XV_BUS_READ_LATCH_EN defined: rd_word <= reg_rdata_i only in STROBE of a
//    high-byte read (snapshot). A later low-byte read returns the same word,
//    giving coherent 16-bit reads of live registers.
//  XV_BUS_READ_LATCH_EN undefined: rd_word <= reg_rdata_i every cycle in
//    IDLE/STROBE; each byte reflects the value current at its own access.
// STRUCTURE
//  - xv package: resp_state_t enum {IDLE, STROBE, WAIT_REL}, plus the
//    XVID_* register-number constants already used by the register core.
//  - One sub-module: xv_sync_bit (SYNC_STAGES-deep synchroniser with reset
//    value 1). Reused for any other asynchronous pin.
// TESTING
//  1 Reset, then write R3 high 8'h12 and low 8'h34 -> one reg_wr_o pulse,
//    reg_num_o = 4'h3, reg_wdata_o = 16'h1234; no pulse on the high byte.
//  2 Hold CS low 20 clocks on a low-byte write to R4 -> exactly one reg_wr_o;
//    second access after CS rises -> second pulse.
//  3 reg_rdata_i = 16'hBEEF for R2; read high then low -> bus_data_o 8'hBE,
//    then 8'hEF; one reg_rd_o, on the low byte only.
//  4 XV_BUS_READ_LATCH_EN: reg_rdata_i 16'hAAAA, read high, change to 16'h5555,
//    read low -> 8'hAA then 8'hAA. Without the macro -> 8'hAA then 8'h55.
//  5 Assert reset_i while in WAIT_REL with CS low; release -> exactly one new
//    strobe, outputs 0 during reset.
//  6 Low-only write 8'h77 after test 1 -> reg_wdata_o = 16'h1277 (hi_byte
//    retained).

Source files
------------

// File: rtl/xosera_bus_responder_pkg.sv
// Shared types and register-number constants for the Xosera host bus path.
package xosera_bus_responder_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STROBE   = 2'd1,
    WAIT_REL = 2'd2
  } resp_state_t;

  localparam logic [3:0] XVID_AUX_ADDR = 4'h0;
  localparam logic [3:0] XVID_CONST    = 4'h1;
  localparam logic [3:0] XVID_RD_ADDR  = 4'h2;
  localparam logic [3:0] XVID_WR_ADDR  = 4'h3;
  localparam logic [3:0] XVID_DATA     = 4'h4;
  localparam logic [3:0] XVID_DATA_2   = 4'h5;
  localparam logic [3:0] XVID_AUX_DATA = 4'h6;
  localparam logic [3:0] XVID_COUNT    = 4'h7;

endpackage

// File: rtl/xosera_bus_responder_sync.sv
// xv_sync_bit: SYNC_STAGES-deep synchroniser for an asynchronous pin; resets to 1.
module xv_sync_bit #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/xosera_bus_responder.sv
// Host 8-bit register bus target: CS sync, byte->word write assembly, byte reads.
// Optional macro XV_BUS_READ_LATCH_EN: snapshot the read word on a high-byte read.
module xosera_bus_responder
  import xosera_bus_responder_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        bus_cs_n_i,
  input  logic        bus_rd_nwr_i,
  input  logic        bus_bytesel_i,
  input  logic [3:0]  bus_reg_num_i,
  input  logic [7:0]  bus_data_i,
  output logic [7:0]  bus_data_o,
  output logic        reg_wr_o,
  output logic        reg_rd_o,
  output logic [3:0]  reg_num_o,
  output logic [15:0] reg_wdata_o,
  input  logic [15:0] reg_rdata_i
);

  logic        cs_sync;
  resp_state_t state_q,   state_d;
  logic        rd_nwr_q,  rd_nwr_d;
  logic        bytesel_q, bytesel_d;
  logic [3:0]  reg_num_q, reg_num_d;
  logic [7:0]  data_q,    data_d;
  logic [7:0]  hi_byte_q, hi_byte_d;
  logic [15:0] rd_word_q, rd_word_d;

  xv_sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_cs_sync (
    .clk    (clk),
    .reset_i(reset_i),
    .d_i    (bus_cs_n_i),
    .q_o    (cs_sync)
  );

  always_comb begin
    state_d   = state_q;
    rd_nwr_d  = rd_nwr_q;
    bytesel_d = bytesel_q;
    reg_num_d = reg_num_q;
    data_d    = data_q;
    hi_byte_d = hi_byte_q;
    rd_word_d = rd_word_q;
    unique case (state_q)
      IDLE: begin
        reg_num_d = bus_reg_num_i;
        if (!cs_sync) begin
          state_d   = STROBE;
          rd_nwr_d  = bus_rd_nwr_i;
          bytesel_d = bus_bytesel_i;
          data_d    = bus_data_i;
        end
      end
      STROBE: begin
        state_d = WAIT_REL;
        if (!rd_nwr_q && !bytesel_q) begin
          hi_byte_d = data_q;
        end
      end
      WAIT_REL: begin
        if (cs_sync) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef XV_BUS_READ_LATCH_EN
    if (state_q == STROBE && rd_nwr_q && !bytesel_q) begin
      rd_word_d = reg_rdata_i;
    end
`else
    if (state_q == IDLE || state_q == STROBE) begin
      rd_word_d = reg_rdata_i;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q   <= IDLE;
      rd_nwr_q  <= 1'b0;
      bytesel_q <= 1'b0;
      reg_num_q <= '0;
      data_q    <= '0;
      hi_byte_q <= '0;
      rd_word_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_nwr_q  <= rd_nwr_d;
      bytesel_q <= bytesel_d;
      reg_num_q <= reg_num_d;
      data_q    <= data_d;
      hi_byte_q <= hi_byte_d;
      rd_word_q <= rd_word_d;
    end
  end

  assign reg_wr_o    = (state_q == STROBE) && !rd_nwr_q && bytesel_q;
  assign reg_rd_o    = (state_q == STROBE) && rd_nwr_q && bytesel_q;
  assign reg_num_o   = reg_num_q;
  assign reg_wdata_o = {hi_byte_q, data_q};
  assign bus_data_o  = bytesel_q ? rd_word_q[7:0] : rd_word_q[15:8];

endmodule
